// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// Receive half of the board UART. Deserializes an 8N1 stream arriving on
// the uart_rx pin into bytes for the 6502 I/O logic. Uses the same fixed
// clocks-per-bit scheme as the transmitter, so one instance of each gives a
// full-duplex port.
//
// Contents: two-flop input synchronizer, start-bit qualifier, bit-sampling
// state machine and a one-byte holding register with a valid/ready handshake.
//
// Parameters
//   CLK_DIV    system clocks per serial bit (4..65535)
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   uart_rx    serial line, idle high, asynchronous to clk
//   rx_data    received byte, meaningful while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer accepts the byte when rx_valid & rx_ready
//   overrun    sticky: a byte was dropped because the holding register was full
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       receiver state machine is not idle
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    // Start edge to start-bit sample offset; not meant to be overridden.
    localparam int unsigned HALF = CLK_DIV / 2;
    localparam int unsigned CW   = $clog2(CLK_DIV);

    // The baud counter counts down and the sample is taken in the cycle it
    // reads zero, so a load of N-1 places the sample N cycles after the load
    // cycle.
    localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchronizer. Both stages reset to the idle (high) level so a
    // reset never looks like a start bit. rxd_s_q is the only view of the
    // line that any decision below uses.
    // -----------------------------------------------------------------------
    logic sync1_q;
    logic rxd_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rxd_s_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Bit-sampling state machine
    // -----------------------------------------------------------------------
    state_e        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;

    logic tick;
    assign tick = (baud_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_q <= S_START;
                        baud_q  <= HALF_LD;
                    end
                end

                S_START: begin
                    if (tick) begin
                        // A line that is high again at mid start bit was
                        // only a glitch: drop it silently.
                        if (!rxd_s_q) begin
                            state_q   <= S_DATA;
                            baud_q    <= DIV_LD;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        // LSB first: each new bit enters at the top.
                        shift_q <= {rxd_s_q, shift_q[7:1]};
                        baud_q  <= DIV_LD;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        // Return straight to IDLE on a good stop bit so a
                        // start bit immediately following is not missed.
                        if (rxd_s_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    // Break or stuck-low line: wait for it to go high
                    // before looking for another start bit.
                    if (rxd_s_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Holding register
    // -----------------------------------------------------------------------
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       overrun_q,  overrun_d;

    logic byte_done;
    logic accept;
    logic load;

    // The byte is complete in the stop-sample cycle; shift_q already holds
    // all eight data bits at that point.
    assign byte_done = (state_q == S_STOP) && tick && rxd_s_q;
    assign accept    = rx_valid_q && rx_ready;
    // An accept in the same cycle frees the register, so that case loads
    // rather than counting as an overrun.
    assign load      = byte_done && (!rx_valid_q || rx_ready);

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        overrun_d  = overrun_q;
        if (accept) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (load) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
        end else if (byte_done) begin
            // Register full and not being drained: keep the old byte.
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
  localparam int D   = 8;
  localparam int H   = D / 2;
  // Clock edges from driving the start bit (just after edge N) to the edge
  // at which the byte lands: 2 sync edges, start sample at T0+H, stop sample
  // 9 bits later, result visible one edge after that.
  localparam int LAT = 3 + H + 9 * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, busy;

  uart_rx_core #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame outcomes are scheduled by edge number when the frame is driven;
  // the holding register follows the handshake rules cycle by cycle.
  typedef struct { logic ferr; logic [7:0] data; } ev_t;
  ev_t sched[int];

  logic       m_valid, m_ovr, m_ferr;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_ovr <= 1'b0; m_ferr <= 1'b0; m_data <= 8'h00;
    end else begin
      m_ferr <= 1'b0;
      if (m_valid && rx_ready) begin
        m_valid <= 1'b0;
        m_ovr   <= 1'b0;
      end
      if (sched.exists(cyc + 1)) begin
        if (sched[cyc + 1].ferr) m_ferr <= 1'b1;
        else if (!m_valid || rx_ready) begin
          m_valid <= 1'b1;
          m_data  <= sched[cyc + 1].data;
        end else m_ovr <= 1'b1;
      end
    end
  end

  // ---------------- monitor / per-cycle compare ----------------
  bit         chk_en = 0;
  logic [7:0] got_q[$];
  int         vcnt = 0;
  int         ferr_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle_outputs",
          {21'd0, rx_valid, overrun, frame_err, (m_valid ? rx_data : 8'h00)},
          {21'd0, m_valid,  m_ovr,   m_ferr,    (m_valid ? m_data  : 8'h00)});
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) vcnt <= vcnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end
  end

  // rx_ready driver: 0 = low, 1 = high, 2 = random, 3 = one-cycle pulse
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0: rx_ready = 1'b0;
      1: rx_ready = 1'b1;
      2: rx_ready = 1'($urandom_range(0, 1));
      default: begin rx_ready = 1'b1; rdy_mode = 0; end
    endcase
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    wait_cyc(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    ev_t ev;
    ev.ferr = !stop_b;
    ev.data = d;
    sched[cyc + LAT] = ev;
    uart_rx = 1'b0;
    wait_cyc(D);
    for (int b = 0; b < 8; b++) begin
      uart_rx = d[b];
      wait_cyc(D);
    end
    uart_rx = stop_b;
    wait_cyc(D);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         hold_low;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vt[8];

  logic [7:0] rd;
  logic       rs;
  int         n0;

  initial begin
    vt[0] = '{8'h00, 1'b1, 0,  1'b0, 8'h00};
    vt[1] = '{8'hFF, 1'b1, 0,  1'b0, 8'hFF};
    vt[2] = '{8'h55, 1'b1, 0,  1'b0, 8'h55};
    vt[3] = '{8'h81, 1'b0, 20, 1'b1, 8'h00};
    vt[4] = '{8'h42, 1'b1, 0,  1'b0, 8'h42};
    vt[5] = '{8'h01, 1'b1, 0,  1'b0, 8'h01};
    vt[6] = '{8'h80, 1'b1, 0,  1'b0, 8'h80};
    vt[7] = '{8'h00, 1'b0, 1,  1'b1, 8'h00};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_overrun", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    chk_en = 1;
    idle(2 * D);

    // table of single frames, consumer always ready
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      got_q.delete();
      ferr_cnt = 0;
      send_frame(vt[i].data, vt[i].stop_b);
      if (vt[i].hold_low > 0) wait_cyc(vt[i].hold_low * D);
      idle(2 * D);
      chk("tbl_ferr", ferr_cnt, {31'd0, vt[i].exp_ferr});
      chk("tbl_count", got_q.size(), vt[i].exp_ferr ? 0 : 1);
      if (!vt[i].exp_ferr && got_q.size() > 0) chk("tbl_data", got_q[0], vt[i].exp_data);
    end

    // exact timing of one frame, consumer not ready
    rdy_mode = 0;
    wait_cyc(2);
    n0 = cyc;
    fork
      send_frame(8'h55, 1'b1);
      begin
        wait_cyc(2);       chk("t1_busy_T0", busy, 0);
        wait_cyc(1);       chk("t1_busy_T0p1", busy, 1);
        wait_cyc(LAT - 4); chk("t1_valid_early", rx_valid, 0);
                           chk("t1_busy_stop", busy, 1);
        wait_cyc(1);       chk("t1_valid_rise", rx_valid, 1);
                           chk("t1_data", rx_data, 8'h55);
                           chk("t1_busy_idle", busy, 0);
                           chk("t1_rise_cycle", cyc - n0, LAT);
      end
    join
    wait_cyc(10);
    chk("t1_valid_hold", rx_valid, 1);
    rdy_mode = 3;
    wait_cyc(1);
    chk("t1_valid_drop", rx_valid, 0);
    chk("t1_overrun", overrun, 0);

    // back-to-back frames, no idle gap
    rdy_mode = 1;
    wait_cyc(2);
    got_q.delete(); vcnt = 0; ferr_cnt = 0;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(2 * D);
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first", got_q[0], 8'hA5);
      chk("b2b_second", got_q[1], 8'h3C);
    end
    chk("b2b_strobes", vcnt, 2);
    chk("b2b_ferr", ferr_cnt, 0);
    chk("b2b_overrun", overrun, 0);

    // 3-clock low glitch
    got_q.delete(); vcnt = 0; ferr_cnt = 0;
    uart_rx = 1'b0;
    wait_cyc(3);
    uart_rx = 1'b1;
    wait_cyc(1);
    chk("glitch_busy", busy, 1);
    wait_cyc(2 * D);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", vcnt, 0);
    chk("glitch_ferr", ferr_cnt, 0);

    // overrun
    rdy_mode = 0;
    wait_cyc(2);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2 * D);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", overrun, 1);
    rdy_mode = 3;
    wait_cyc(1);
    chk("ovr_accept_valid", rx_valid, 0);
    chk("ovr_accept_flag", overrun, 0);
    wait_cyc(2);
    send_frame(8'h33, 1'b1);
    idle(2 * D);
    chk("ovr_next_valid", rx_valid, 1);
    chk("ovr_next_data", rx_data, 8'h33);
    chk("ovr_next_flag", overrun, 0);

    // reset during data bit 4 of 0xF0 (holding register still full of 0x33)
    uart_rx = 1'b0;
    wait_cyc(D);
    wait_cyc(4 * D);
    uart_rx = 1'b1;
    wait_cyc(3);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(5 * D);
    chk("post_rst_valid", rx_valid, 0);
    chk("post_rst_busy", busy, 0);
    rdy_mode = 1;
    wait_cyc(2);
    got_q.delete();
    send_frame(8'h0F, 1'b1);
    idle(2 * D);
    chk("post_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("post_rst_data", got_q[0], 8'h0F);

    // randomized frames against the model, random consumer
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 9) != 0);
      send_frame(rd, rs);
      if (!rs) begin
        wait_cyc($urandom_range(0, 2 * D));
        idle(D + $urandom_range(0, D));
      end else if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 3 * D));
      end
    end
    idle(3 * D);
    rdy_mode = 1;
    wait_cyc(4);
    chk("final_valid", rx_valid, 0);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive-side UART for the upduino design: deserializes an 8N1 asynchronous serial stream arriving on the board's `uart_rx` pin into bytes for the 6502 I/O logic. It is the counterpart of the design's UART transmitter and uses the same fixed clocks-per-bit scheme, so one instance paired with the transmitter gives a full-duplex port. It contains the input synchronizer, the start-bit qualifier, the bit-sampling state machine and a one-byte holding register with a valid/ready handshake.

## Interface
- `CLK_DIV`, 16: system clocks per serial bit; legal range 4..65535.
- `HALF`, `CLK_DIV/2` (integer division, derived, not overridable): offset from start edge to the start-bit sample.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts the byte in the cycle where `rx_valid`&`rx_ready`=1.
- `overrun`  out  1  sticky: a byte was lost because the holding register was full.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  state machine not in IDLE.

## Operation
- Synchronizer: two flops on `uart_rx`, both reset to 1; `rxd_s` is the second stage. All decisions use `rxd_s` only.
- States: IDLE, START, DATA, STOP, WAIT_IDLE. Bit counter is 0..7. Baud counter is `$clog2(CLK_DIV)` bits.
- IDLE: on `rxd_s`=0, go to START and load the baud counter for HALF clocks.
- START: at expiry, sample `rxd_s`. If 0, go to DATA with counter = CLK_DIV. If 1, it is a false start (glitch): return to IDLE with no output and no flag.
- DATA: at each expiry, shift `rxd_s` in LSB first and reload CLK_DIV. After bit 7, go to STOP.
- STOP: at expiry, sample `rxd_s`.
  - If 1: the byte is complete; go to IDLE.
  - If 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxd_s`=1 (break or line held low), then go to IDLE. No start is detected while in this state.
- Holding register on a completed byte:
  - If `rx_valid`=0, or `rx_ready`=1 in that same cycle: load `rx_data` and set `rx_valid`. The simultaneous accept-and-load case is not an overrun.
  - Otherwise keep the old byte, discard the new one, and set `overrun`.
- `rx_valid` clears on accept unless a new byte loads in the same cycle.
- `overrun` clears on the next accepted byte, i.e. the cycle after the handshake.
- `rx_data` holds its value after accept; it is undefined for the consumer when `rx_valid`=0.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `overrun`=0, `frame_err`=0, `busy`=0, state IDLE, both sync flops=1.
- Reset asserted mid-frame aborts immediately. A byte being received is never presented.
- Let T0 be the first cycle with `rxd_s`=0 in IDLE; T0 is 2 clocks after the pin edge.
  - Start sample at T0+HALF.
  - Data bit i (0..7) sampled at T0+HALF+(i+1)·CLK_DIV.
  - Stop bit sampled at T0+HALF+9·CLK_DIV.
- `rx_valid` rises, or `frame_err` pulses, in the cycle after the stop sample.
- The state machine is in IDLE in that same cycle, so the next start bit can be detected immediately. Back-to-back frames with zero idle bits are received.
- `busy`=1 from T0+1 until the IDLE return.
- Tolerance: the sample point sits at mid-bit, which gives ±(HALF−1)/CLK_DIV bit-time drift over 10 bits.

## Test plan
- CLK_DIV=8; send 0x55 with ideal timing, `rx_ready`=0 → `rx_valid` rises at the computed cycle with `rx_data`=0x55. `rx_valid` stays high until `rx_ready` is pulsed, then drops next cycle; `overrun`=0.
- Back-to-back 0xA5 then 0x3C with no idle gap, `rx_ready` tied 1 → two single-cycle `rx_valid` strobes, data 0xA5 then 0x3C, no flags.
- Low glitch of 3 clocks on `uart_rx` (shorter than HALF) → no `rx_valid`, no `frame_err`, `busy` returns to 0.
- Frame 0x81 with stop bit 0, line then held low for 20 bit-times before returning high → one `frame_err` pulse, no `rx_valid`. The next valid frame 0x42 is received correctly.
- Send 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11, `overrun`=1. Pulse `rx_ready` → `rx_valid`=0 and `overrun`=0. Then 0x33 is received normally.
- Assert `rst_n`=0 during data bit 4 of 0xF0, release → all outputs at reset values, no byte presented. The following frame 0x0F is received as 0x0F.
